// File: rtl/risc_div_core_if.sv
// Request/result bundle for the iterative divider.
// The master issues operands; the slave returns tagged results.
interface risc_div_core_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [TAG_W-1:0] rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [TAG_W-1:0] rd_out;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, rd_in,
    input  busy, done, quotient, remainder,
    input  rd_out, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, rd_in,
    output busy, done, quotient, remainder,
    output rd_out, div_by_zero
  );
endinterface

// File: rtl/risc_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Results and tag are registered so a negedge consumer sees stable data.
module risc_div_core #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  risc_div_core_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [TAG_W-1:0] tag;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // One restoring step; the extra top bit keeps large divisors exact.
  always_comb begin
    t     = {r, q[WIDTH-1]};
    r_nxt = t[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], 1'b0};
    if (t >= {1'b0, d}) begin
      r_nxt = WIDTH'(t - {1'b0, d});
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      r               <= '0;
      q               <= '0;
      d               <= '0;
      tag             <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.rd_out      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              state    <= RUN;
              bus.busy <= 1'b1;
              r        <= '0;
              q        <= bus.dividend;
              d        <= bus.divisor;
              tag      <= bus.rd_in;
              cnt      <= CW'(WIDTH - 1);
            end else begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.rd_out      <= bus.rd_in;
              bus.div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r <= r_nxt;
          q <= q_nxt;
          if (cnt == '0) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_nxt;
            bus.remainder   <= r_nxt;
            bus.rd_out      <= tag;
            bus.div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
